// File: rtl/div_ctrl_if.sv
// Control/status bundle between the restoring-division sequencer (slave) and
// the requester plus remainder/ALU datapath that it steers (master).
interface div_ctrl_if #(
  parameter int CNT_W = 6
);
  logic             Start;
  logic             Neg_Rem;
  logic             Divisor_zero;
  logic [5:0]       ALU_ctrl;
  logic [1:0]       HiLo_ctrl;
  logic             Shift_in;
  logic             Wr_hi;
  logic             Ready;
  logic             Done;
  logic [CNT_W-1:0] Iter;
  logic             Div_err;

  modport master (
    output Start, Neg_Rem, Divisor_zero,
    input  ALU_ctrl, HiLo_ctrl, Shift_in, Wr_hi, Ready, Done, Iter, Div_err
  );

  modport slave (
    input  Start, Neg_Rem, Divisor_zero,
    output ALU_ctrl, HiLo_ctrl, Shift_in, Wr_hi, Ready, Done, Iter, Div_err
  );
endinterface

// File: rtl/div_ctrl.sv
// Moore sequencer for a restoring divider: one SUB/CHECK/(RESTORE)/SHIFT pass per bit.
// Define DIV_ZERO_CHECK_EN to short-circuit a zero divisor straight to DONE with Div_err.
module div_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  div_ctrl_if.slave   bus
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] LOAD    = 4'd1;
  localparam logic [3:0] SHL0    = 4'd2;
  localparam logic [3:0] SUB     = 4'd3;
  localparam logic [3:0] CHECK   = 4'd4;
  localparam logic [3:0] RESTORE = 4'd5;
  localparam logic [3:0] SHIFT   = 4'd6;
  localparam logic [3:0] FINAL   = 4'd7;
  localparam logic [3:0] DONE    = 4'd8;

  localparam logic [5:0] ALU_HOLD = 6'b000000;
  localparam logic [5:0] ALU_ADD  = 6'b000001;
  localparam logic [5:0] ALU_SUB  = 6'b000010;

  localparam logic [1:0] HL_HOLD = 2'b00;
  localparam logic [1:0] HL_LOAD = 2'b01;
  localparam logic [1:0] HL_SHL  = 2'b10;
  localparam logic [1:0] HL_SHR  = 2'b11;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [3:0]       state;
  logic [3:0]       state_nxt;
  logic [CNT_W-1:0] iter;
  logic             q_bit;
  logic             zero_hit;

`ifdef DIV_ZERO_CHECK_EN
  logic err;

  assign zero_hit = bus.Divisor_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state == IDLE && bus.Start) begin
      err <= bus.Divisor_zero;
    end else if (state == DONE) begin
      err <= 1'b0;
    end
  end

  assign bus.Div_err = (state == DONE) && err;
`else
  logic unused_dz;

  assign unused_dz   = bus.Divisor_zero;
  assign zero_hit    = 1'b0;
  assign bus.Div_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.Start) state_nxt = zero_hit ? DONE : LOAD;
      LOAD:    state_nxt = SHL0;
      SHL0:    state_nxt = SUB;
      SUB:     state_nxt = CHECK;
      CHECK:   state_nxt = bus.Neg_Rem ? RESTORE : SHIFT;
      RESTORE: state_nxt = SHIFT;
      SHIFT:   state_nxt = (iter == LAST_ITER) ? FINAL : SUB;
      FINAL:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state, iteration count and the quotient bit decided in CHECK
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      iter  <= '0;
      q_bit <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            iter  <= '0;
            q_bit <= 1'b0;
          end
        end
        CHECK:   q_bit <= ~bus.Neg_Rem;
        RESTORE: q_bit <= 1'b0;
        SHIFT:   iter  <= iter + CNT_W'(1);
        default: ;
      endcase
    end
  end

  // outputs depend on state (and registered q_bit/iter) only
  always_comb begin
    bus.ALU_ctrl  = ALU_HOLD;
    bus.HiLo_ctrl = HL_HOLD;
    bus.Shift_in  = 1'b0;
    bus.Wr_hi     = 1'b0;
    bus.Ready     = 1'b0;
    bus.Done      = 1'b0;
    case (state)
      IDLE:    bus.Ready = 1'b1;
      LOAD:    bus.HiLo_ctrl = HL_LOAD;
      SHL0:    bus.HiLo_ctrl = HL_SHL;
      SUB: begin
        bus.ALU_ctrl = ALU_SUB;
        bus.Wr_hi    = 1'b1;
      end
      RESTORE: begin
        bus.ALU_ctrl = ALU_ADD;
        bus.Wr_hi    = 1'b1;
      end
      SHIFT: begin
        bus.HiLo_ctrl = HL_SHL;
        bus.Shift_in  = q_bit;
      end
      FINAL:   bus.HiLo_ctrl = HL_SHR;
      DONE:    bus.Done = 1'b1;
      default: ;
    endcase
  end

  assign bus.Iter = iter;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: an ideal remainder-register datapath reacts to the
// controls, expectations come from plain division arithmetic, a monitor checks each Done.
`timescale 1ns/1ps
module tb_div_ctrl;
  localparam int WIDTH    = 32;
  localparam int CNT_W    = 6;
  localparam int BASE_LAT = 4 + 3 * WIDTH;

  typedef struct {
    longint      exp_done;
    bit          chk_data;
    logic [31:0] q;
    logic [31:0] r;
    int          iter;
    bit          err;
    int          ones;
    int          restores;
    int          hilo_ops;
  } exp_t;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  longint cyc   = 0;
  int     n_checks = 0;
  int     n_errors = 0;

  exp_t   sb[$];
  exp_t   mon_e;
  int     ones_c = 0, rest_c = 0, hilo_c = 0;

  longint      m_hi = 0;
  logic [31:0] m_lo = '0;
  logic [31:0] m_dividend = '0;
  longint      m_divisor = 1;
  int          nr_mode = 1;

  div_ctrl_if #(.CNT_W(CNT_W)) bus ();

  div_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle=%0d required=<50000", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ideal datapath: remainder register {hi, lo} with unbounded hi, ALU on hi.
  // Neg_Rem carries the true sign only where the controller looks at it; elsewhere noise.
  always @(negedge clk) begin
    case (bus.HiLo_ctrl)
      2'b01: begin m_hi = 0; m_lo = m_dividend; end
      2'b10: begin
        m_hi = (m_hi <<< 1) | longint'(m_lo[31]);
        m_lo = {m_lo[30:0], bus.Shift_in};
      end
      2'b11: m_hi = m_hi >>> 1;
      default: ;
    endcase
    if (bus.Wr_hi && bus.ALU_ctrl == 6'b000010) m_hi = m_hi - m_divisor;
    if (bus.Wr_hi && bus.ALU_ctrl == 6'b000001) m_hi = m_hi + m_divisor;
    case (nr_mode)
      1:       bus.Neg_Rem = 1'b0;
      2:       bus.Neg_Rem = 1'b1;
      default: begin
        if (!bus.Ready && !bus.Done && !bus.Wr_hi && bus.HiLo_ctrl == 2'b00 &&
            bus.ALU_ctrl == 6'b000000)
          bus.Neg_Rem = (m_hi < 0);
        else
          bus.Neg_Rem = 1'($urandom);
      end
    endcase
  end

  // Monitor: pops one expectation per Done pulse; per-run activity counters
  always @(negedge clk) begin
    if (rst_n) begin
      chk("div_err_outside_done", longint'(bus.Div_err & ~bus.Done), 0);
      if (bus.Done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got Done=1 expected none pending (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("done_cycle", cyc, mon_e.exp_done);
          chk("iter_at_done", longint'(bus.Iter), longint'(mon_e.iter));
          chk("div_err_at_done", longint'(bus.Div_err), longint'(mon_e.err));
          chk("shift_in_ones", longint'(ones_c), longint'(mon_e.ones));
          chk("restore_count", longint'(rest_c), longint'(mon_e.restores));
          chk("hilo_ops", longint'(hilo_c), longint'(mon_e.hilo_ops));
          if (mon_e.chk_data) begin
            chk("quotient", longint'(m_lo), longint'(mon_e.q));
            chk("remainder", m_hi, longint'(mon_e.r));
          end
        end
      end else if (sb.size() > 0 && cyc > sb[0].exp_done) begin
        n_checks++;
        n_errors++;
        $display("FAIL done_missing: no Done by cycle %0d expected at %0d", cyc, sb[0].exp_done);
        void'(sb.pop_front());
      end
    end
    if (bus.Ready || !rst_n) begin
      ones_c = 0; rest_c = 0; hilo_c = 0;
    end else begin
      ones_c += int'(bus.HiLo_ctrl == 2'b10 && bus.Shift_in);
      rest_c += int'(bus.ALU_ctrl == 6'b000001);
      hilo_c += int'(bus.HiLo_ctrl != 2'b00);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.Ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", longint'(bus.Ready), 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() > 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", longint'(sb.size()), 0);
  endtask

  // mode 0: model-driven Neg_Rem, 1: held 0, 2: held 1
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input int mode, input bit dz);
    exp_t        e;
    bit          zc;
    logic [31:0] q;
    int          rcnt;
    wait_ready();
`ifdef DIV_ZERO_CHECK_EN
    zc = dz;
`else
    zc = 1'b0;
`endif
    nr_mode           = mode;
    m_dividend        = a;
    m_divisor         = longint'(b);
    bus.Divisor_zero  = dz;
    e.chk_data        = 1'b0;
    e.q               = '0;
    e.r               = '0;
    if (zc) begin
      e.exp_done = cyc + 1;
      e.iter     = 0;
      e.err      = 1'b1;
      e.ones     = 0;
      e.restores = 0;
      e.hilo_ops = 0;
    end else begin
      if (mode == 1)      q = '1;
      else if (mode == 2) q = '0;
      else                q = a / b;
      rcnt       = WIDTH - $countones(q);
      e.exp_done = cyc + BASE_LAT + rcnt;
      e.iter     = WIDTH;
      e.err      = 1'b0;
      e.ones     = WIDTH - rcnt;
      e.restores = rcnt;
      e.hilo_ops = WIDTH + 3;
      if (mode == 0 && b != 0) begin
        e.chk_data = 1'b1;
        e.q        = a / b;
        e.r        = a % b;
      end
    end
    sb.push_back(e);
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  initial begin
    exp_t        e;
    longint      c0;
    int          n;
    logic [31:0] a, b;

    bus.Start        = 1'b0;
    bus.Divisor_zero = 1'b0;
    rst_n            = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", longint'(bus.Ready), 1);
    chk("rst_done", longint'(bus.Done), 0);
    chk("rst_div_err", longint'(bus.Div_err), 0);
    chk("rst_iter", longint'(bus.Iter), 0);
    chk("rst_alu", longint'(bus.ALU_ctrl), 0);
    chk("rst_hilo", longint'(bus.HiLo_ctrl), 0);
    chk("rst_shift_in", longint'(bus.Shift_in), 0);
    chk("rst_wr_hi", longint'(bus.Wr_hi), 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'd1000, 32'd3, 1, 1'b0);
    wait_drain();
    issue(32'd1000, 32'd3, 2, 1'b0);
    wait_drain();
    issue(32'd100, 32'd7, 0, 1'b0);
    wait_drain();
    issue(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    wait_drain();
    issue(32'd5, 32'hFFFF_FFFF, 0, 1'b0);
    wait_drain();
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 1) == 1) b = $urandom_range(1, 300);
      if (b == 0) b = 32'd1;
      issue(a, b, 0, 1'b0);
      wait_drain();
    end

    issue(32'd55, 32'd0, 1, 1'b1);
    wait_drain();
    bus.Divisor_zero = 1'b0;

    // abort a run at cycle 40 with Start asserted alongside the reset
    issue(32'd123456, 32'd789, 0, 1'b0);
    repeat (39) @(negedge clk);
    rst_n     = 1'b0;
    bus.Start = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_ready", longint'(bus.Ready), 1);
    chk("midrst_iter", longint'(bus.Iter), 0);
    chk("midrst_alu", longint'(bus.ALU_ctrl), 0);
    chk("midrst_hilo", longint'(bus.HiLo_ctrl), 0);
    chk("midrst_shift_in", longint'(bus.Shift_in), 0);
    chk("midrst_wr_hi", longint'(bus.Wr_hi), 0);
    chk("midrst_done", longint'(bus.Done), 0);
    rst_n     = 1'b1;
    bus.Start = 1'b0;
    @(negedge clk);
    chk("start_in_reset_ignored", longint'(bus.Ready), 1);
    repeat (150) @(negedge clk);

    // Start held high: back-to-back runs, one Ready cycle between them
    wait_ready();
    nr_mode   = 1;
    c0        = cyc;
    bus.Start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e.exp_done = c0 + BASE_LAT + k * (BASE_LAT + 1);
      e.chk_data = 1'b0;
      e.q        = '0;
      e.r        = '0;
      e.iter     = WIDTH;
      e.err      = 1'b0;
      e.ones     = WIDTH;
      e.restores = 0;
      e.hilo_ops = WIDTH + 3;
      sb.push_back(e);
    end
    n = 0;
    while (cyc < c0 + 2 * (BASE_LAT + 1) + BASE_LAT && n < 1000) begin
      @(negedge clk);
      n++;
    end
    bus.Start = 1'b0;
    wait_drain();
    repeat (5) @(negedge clk);
    chk("idle_after_held_start", longint'(bus.Ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
